hmax_accumulator: RTL and testbench

HMAX_ACCUMULATOR -- requirements
Module: hmax_accumulator

---
 rtl/pooling_pkg.sv | 24 ++
 rtl/vec_signed_max.sv | 19 +
 rtl/hmax_accumulator.sv | 119 +++++++++++
 tb/tb_hmax_accumulator.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pooling_pkg.sv
// Shared types and defaults for the pooling pipeline (horizontal-max stage and friends).
package pooling_pkg;

  localparam int DATA_WIDTH_DEF      = 32;
  localparam int SA_LENGTH_DEF       = 256;
  localparam int MAX_FILTER_SIZE_DEF = 7;

  // Counts rows already absorbed into the current window: 0 .. MAX_FILTER_SIZE_DEF-1.
  localparam int ROW_CNT_W = (MAX_FILTER_SIZE_DEF > 1) ? $clog2(MAX_FILTER_SIZE_DEF) : 1;
  typedef logic [ROW_CNT_W-1:0] row_cnt_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } pool_state_e;

  // Window height actually used: 0 means a single row, oversize requests clamp to the maximum.
  function automatic int unsigned effective_size(input int unsigned cfg, input int unsigned max_fs);
    if (cfg == 0)      return 1;
    if (cfg > max_fs)  return max_fs;
    return cfg;
  endfunction

endpackage

// File: rtl/vec_signed_max.sv
// Element-wise signed maximum of two row vectors; purely combinational.
module vec_signed_max
  import pooling_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SA_LENGTH  = SA_LENGTH_DEF
) (
  input  logic signed [DATA_WIDTH-1:0] a [SA_LENGTH],
  input  logic signed [DATA_WIDTH-1:0] b [SA_LENGTH],
  output logic signed [DATA_WIDTH-1:0] y [SA_LENGTH]
);

  always_comb begin
    for (int j = 0; j < SA_LENGTH; j++) begin
      y[j] = (a[j] > b[j]) ? a[j] : b[j];
    end
  end

endmodule

// File: rtl/hmax_accumulator.sv
// Folds consecutive systolic-array rows into one element-wise maximum per pooling window
// and hands the result to the vertical-max stage over a valid/ready interface.
module hmax_accumulator
  import pooling_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int SA_LENGTH       = SA_LENGTH_DEF,
  parameter int MAX_FILTER_SIZE = MAX_FILTER_SIZE_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [$clog2(MAX_FILTER_SIZE+1)-1:0]       cfg_filter_size,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic signed [DATA_WIDTH-1:0]               in_row [SA_LENGTH],
  input  logic                                       in_last,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic signed [DATA_WIDTH-1:0]               out_hmax [SA_LENGTH],
  output logic                                       out_last,
  output logic                                       busy
);

  localparam int CFG_W = $clog2(MAX_FILTER_SIZE+1);

  pool_state_e             state_q,     state_d;
  row_cnt_t                row_cnt_q,   row_cnt_d;
  logic [CFG_W-1:0]        fsize_q,     fsize_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q,  out_last_d;
  logic signed [DATA_WIDTH-1:0] acc_q  [SA_LENGTH];
  logic signed [DATA_WIDTH-1:0] acc_d  [SA_LENGTH];
  logic signed [DATA_WIDTH-1:0] hmax_q [SA_LENGTH];
  logic signed [DATA_WIDTH-1:0] hmax_d [SA_LENGTH];
  logic signed [DATA_WIDTH-1:0] max_res [SA_LENGTH];

  logic             accept;
  logic             final_row;
  logic [CFG_W-1:0] eff_size;

  vec_signed_max #(
    .DATA_WIDTH (DATA_WIDTH),
    .SA_LENGTH  (SA_LENGTH)
  ) u_vec_signed_max (
    .a (acc_q),
    .b (in_row),
    .y (max_res)
  );

  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_hmax  = hmax_q;
  assign busy      = (state_q == ST_ACCUM);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    fsize_d     = fsize_q;
    acc_d       = acc_q;
    hmax_d      = hmax_q;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q;

    accept = in_valid && in_ready;

    // A new window samples the configuration; an open window keeps what it latched.
    if (state_q == ST_IDLE) begin
      eff_size = CFG_W'(effective_size(32'(cfg_filter_size), MAX_FILTER_SIZE));
    end else begin
      eff_size = fsize_q;
    end
    final_row = in_last || ((int'(row_cnt_q) + 1) >= int'(eff_size));

    if (accept) begin
      fsize_d = eff_size;
      if (final_row) begin
        if (state_q == ST_IDLE) hmax_d = in_row;
        else                    hmax_d = max_res;
        out_valid_d = 1'b1;
        out_last_d  = in_last;
        row_cnt_d   = '0;
        state_d     = ST_IDLE;
      end else begin
        // First row loads as-is so all-negative windows survive without a zero seed.
        if (state_q == ST_IDLE) acc_d = in_row;
        else                    acc_d = max_res;
        row_cnt_d = row_cnt_q + row_cnt_t'(1);
        state_d   = ST_ACCUM;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      fsize_q     <= CFG_W'(1);
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      // NOTE: accumulator and output arrays are ordinary flops here and are cleared element by element.
      for (int j = 0; j < SA_LENGTH; j++) begin
        acc_q[j]  <= '0;
        hmax_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      fsize_q     <= fsize_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      acc_q       <= acc_d;
      hmax_q      <= hmax_d;
    end
  end

endmodule

// File: tb/tb_hmax_accumulator.sv
// Self-checking bench: window-level reference model compared every cycle, plus directed literal cases.
module tb_hmax_accumulator;

  localparam int DW  = 16;
  localparam int SA  = 8;
  localparam int MF  = 7;
  localparam int MF2 = 5;

  typedef logic signed [DW-1:0] row_t [SA];

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] cfg_filter_size = 3'd1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  row_t       in_row;
  logic       in_ready, out_valid, out_last, busy;
  row_t       out_hmax;

  logic       in_valid2 = 1'b0;
  logic       in_ready2, out_valid2, out_last2, busy2;
  row_t       out_hmax2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hmax_accumulator #(.DATA_WIDTH(DW), .SA_LENGTH(SA), .MAX_FILTER_SIZE(MF)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_filter_size(cfg_filter_size),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_hmax(out_hmax),
    .out_last(out_last), .busy(busy)
  );

  // Second instance with a smaller maximum so an oversize request is representable on the port.
  hmax_accumulator #(.DATA_WIDTH(DW), .SA_LENGTH(SA), .MAX_FILTER_SIZE(MF2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_filter_size(3'd7),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_row(in_row), .in_last(1'b0),
    .out_valid(out_valid2), .out_ready(1'b1), .out_hmax(out_hmax2),
    .out_last(out_last2), .busy(busy2)
  );

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input row_t act, input row_t exp);
    int k = 0;
    for (int j = 0; j < SA; j++) begin
      if (act[j] !== exp[j]) begin
        k = j;
        break;
      end
    end
    check(name, act[k], exp[k]);
  endtask

  function automatic row_t cst(input int v);
    row_t r;
    for (int j = 0; j < SA; j++) r[j] = DW'(v);
    return r;
  endfunction

  // ---------------- reference model ----------------
  row_t win_q[$];
  int   win_eff = 1;
  bit   m_valid = 1'b0;
  bit   m_last  = 1'b0;
  row_t m_hmax  = cst(0);

  function automatic int model_eff(input int cfg);
    if (cfg == 0) return 1;
    if (cfg > MF) return MF;
    return cfg;
  endfunction

  function automatic row_t window_max();
    row_t r = win_q[0];
    for (int i = 1; i < win_q.size(); i++)
      for (int j = 0; j < SA; j++)
        if (win_q[i][j] > r[j]) r[j] = win_q[i][j];
    return r;
  endfunction

  always @(negedge clk) begin
    bit rdy, take;
    if (!rst_n) begin
      win_q.delete();
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_hmax  = cst(0);
    end
    rdy  = !m_valid || out_ready;
    take = m_valid && out_ready;
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, m_valid);
    check("busy", busy, win_q.size() != 0);
    if (m_valid) begin
      check("out_last", out_last, m_last);
      check_vec("out_hmax", out_hmax, m_hmax);
    end
    if (rst_n) begin
      if (in_valid && rdy) begin
        if (win_q.size() == 0) win_eff = model_eff(int'(cfg_filter_size));
        win_q.push_back(in_row);
        if (win_q.size() == win_eff || in_last) begin
          m_hmax  = window_max();
          m_last  = in_last;
          m_valid = 1'b1;
          win_q.delete();
        end else if (take) begin
          m_valid = 1'b0;
        end
      end else if (take) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input row_t r, input bit last);
    bit got = 1'b0;
    in_row   = r;
    in_last  = last;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("in_ready_timeout", 0, 1);
    sync();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_const(input int v, input bit last);
    send_vec(cst(v), last);
  endtask

  initial begin
    in_row = cst(0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check_vec("rst_out_hmax", out_hmax, cst(0));
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    sync();

    // Window of 3: 5, -2, 9
    out_ready = 1'b1;
    cfg_filter_size = 3'd3;
    send_const(5, 0);
    send_const(-2, 0);
    check("q033_no_early_valid", out_valid, 0);
    send_const(9, 0);
    @(negedge clk);
    check("q033_valid", out_valid, 1);
    check_vec("q033_hmax", out_hmax, cst(9));
    check("q033_last", out_last, 0);
    sync();

    // All-negative window of 2
    cfg_filter_size = 3'd2;
    send_const(-7, 0);
    send_const(-3, 0);
    @(negedge clk);
    check_vec("q034_hmax", out_hmax, cst(-3));
    sync();

    // Early flush by in_last
    cfg_filter_size = 3'd4;
    send_const(1, 0);
    send_const(8, 1);
    @(negedge clk);
    check("q035_valid", out_valid, 1);
    check_vec("q035_hmax", out_hmax, cst(8));
    check("q035_last", out_last, 1);
    check("q035_busy", busy, 0);
    sync();

    // Size-1 streaming with backpressure
    cfg_filter_size = 3'd1;
    send_const(100, 0);
    out_ready = 1'b0;
    in_row    = cst(101);
    in_valid  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("q036_stall_ready", in_ready, 0);
      check_vec("q036_frozen", out_hmax, cst(100));
    end
    sync();
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_row = cst(100 + i);
      @(negedge clk);
      check("q036_full_rate", in_ready, 1);
      check_vec("q036_stream", out_hmax, cst(100 + i - 1));
      sync();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_vec("q036_tail", out_hmax, cst(109));
    sync();

    // cfg 0 -> one row; cfg 7 latched, mid-window change ignored
    cfg_filter_size = 3'd0;
    send_const(3, 0);
    @(negedge clk);
    check("q037_cfg0_valid", out_valid, 1);
    check_vec("q037_cfg0_hmax", out_hmax, cst(3));
    sync();
    cfg_filter_size = 3'd7;
    for (int i = 1; i <= 6; i++) begin
      send_const(i, 0);
      cfg_filter_size = 3'd2;
    end
    check("q037_cfg7_busy", busy, 1);
    check("q037_cfg7_no_valid", out_valid, 0);
    send_const(7, 0);
    @(negedge clk);
    check("q037_cfg7_valid", out_valid, 1);
    check_vec("q037_cfg7_hmax", out_hmax, cst(7));
    check("q037_cfg7_busy_after", busy, 0);
    sync();

    // Oversize request clamps to the maximum on the second instance
    for (int i = 1; i <= 4; i++) begin
      in_row = cst(i);
      in_valid2 = 1'b1;
      sync();
    end
    check("clamp_busy", busy2, 1);
    check("clamp_no_valid", out_valid2, 0);
    in_row = cst(5);
    sync();
    in_valid2 = 1'b0;
    check("clamp_valid", out_valid2, 1);
    check_vec("clamp_hmax", out_hmax2, cst(5));
    check("clamp_ready", in_ready2, 1);
    sync();

    // Reset mid-window discards the partial window
    cfg_filter_size = 3'd3;
    send_const(50, 0);
    send_const(50, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("q038_rst_valid", out_valid, 0);
    check("q038_rst_busy", busy, 0);
    check_vec("q038_rst_hmax", out_hmax, cst(0));
    sync();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("q038_no_ghost", out_valid, 0);
      check("q038_ready", in_ready, 1);
    end
    sync();
    send_const(-1, 0);
    send_const(-5, 0);
    check("q038_fresh_not_done", out_valid, 0);
    send_const(-2, 0);
    @(negedge clk);
    check("q038_fresh_valid", out_valid, 1);
    check_vec("q038_fresh_hmax", out_hmax, cst(-1));
    sync();

    // Randomized traffic; the model checks every cycle
    for (int c = 0; c < 600; c++) begin
      row_t r;
      for (int j = 0; j < SA; j++) r[j] = DW'(int'($urandom_range(40)) - 20);
      in_row          = r;
      in_valid        = ($urandom_range(9) < 7);
      in_last         = ($urandom_range(9) < 1);
      cfg_filter_size = 3'($urandom_range(7));
      out_ready       = ($urandom_range(9) < 7);
      sync();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (5) sync();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
